// File: rtl/quad_emu_pkg.sv
// Shared constants, types and helpers for the quad_emu trackball/spinner emulator.
// Imported by the interface, the per-axis channel and the top level.
package quad_emu_pkg;

    localparam int unsigned MODE_CLKDIR = 0;
    localparam int unsigned MODE_QUAD   = 1;

    // Width of one axis slice of the incoming motion packet.
    localparam int unsigned DELTA_W = 9;

    typedef enum logic [1:0] {
        SPEED_X1      = 2'd0,
        SPEED_X2      = 2'd1,
        SPEED_HALF    = 2'd2,
        SPEED_QUARTER = 2'd3
    } speed_e;

    typedef logic [DELTA_W-1:0] delta_t;

    // Two-phase encoder pattern for a free-running phase: 00, 01, 11, 10.
    function automatic logic [1:0] gray2(input logic [1:0] phase);
        return {phase[1], phase[1] ^ phase[0]};
    endfunction

endpackage

// File: rtl/quad_emu_if.sv
// Motion-packet input and encoder-output bundle between the input adapters,
// the emulator and the game's encoder latches.
interface quad_emu_if #(
    parameter int unsigned AXES = 2
);
    import quad_emu_pkg::*;

    logic                    in_valid;
    logic [AXES*DELTA_W-1:0] in_delta;
    logic [1:0]              speed;
    logic [AXES-1:0]         flip;
    logic [AXES-1:0]         q_a;
    logic [AXES-1:0]         q_b;
    logic [AXES-1:0]         busy;

    modport master (
        output in_valid, in_delta, speed, flip,
        input  q_a, q_b, busy
    );

    modport slave (
        input  in_valid, in_delta, speed, flip,
        output q_a, q_b, busy
    );

endinterface

// File: rtl/quad_emu_axis.sv
// One emulator channel: delta scaler, saturating signed backlog, backlog-paced
// step divider and clock/direction or quadrature output stage.
module quad_emu_axis
    import quad_emu_pkg::*;
#(
    parameter int unsigned MODE       = MODE_CLKDIR,
    parameter int unsigned ACC_W      = 10,
    parameter int unsigned BASE_DIV   = 3500,
    parameter int unsigned RATE_SHIFT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  delta_t       delta,
    input  logic [1:0]   speed,
    input  logic         flip,
    output logic         q_a,
    output logic         q_b,
    output logic         busy
);

    // Wide enough that acc + scaled +/- 1 can never wrap before saturation.
    localparam int unsigned SUM_W = ACC_W + DELTA_W + 3;

    localparam logic signed [SUM_W-1:0] SUM_ONE = {{(SUM_W-1){1'b0}}, 1'b1};
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [31:0]             cnt_q, cnt_d;
    logic                    qa_q, qb_q, busy_q;
    logic                    qa_d, qb_d;

    logic                    neg_in;
    logic [DELTA_W-1:0]      mag_in;
    logic [DELTA_W:0]        mag_sc;
    logic signed [SUM_W-1:0] scaled;
    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] sum;

    logic                    acc_neg;
    logic [ACC_W-1:0]        acc_abs;
    logic [31:0]             abs_u;
    logic [31:0]             mag_u;
    logic [31:0]             period;
    logic                    step;
    logic                    dir_neg;

    // Scale the magnitude so right shifts truncate toward zero, then restore sign.
    always_comb begin
        neg_in = delta[DELTA_W-1];
        mag_in = neg_in ? -delta : delta;
        case (speed_e'(speed))
            SPEED_X1:      mag_sc = {1'b0, mag_in};
            SPEED_X2:      mag_sc = {mag_in, 1'b0};
            SPEED_HALF:    mag_sc = {2'b00, mag_in[DELTA_W-1:1]};
            SPEED_QUARTER: mag_sc = {3'b000, mag_in[DELTA_W-1:2]};
            default:       mag_sc = {1'b0, mag_in};
        endcase
        scaled = {{(SUM_W-DELTA_W-1){1'b0}}, mag_sc};
        if (neg_in) begin
            scaled = -scaled;
        end
    end

    always_comb begin
        acc_neg = acc_q[ACC_W-1];
        acc_abs = acc_neg ? -acc_q : acc_q;
        abs_u   = 32'(acc_abs);
        mag_u   = (abs_u > 32'd255) ? 32'd255 : abs_u;
        period  = BASE_DIV + ((32'd255 - mag_u) << RATE_SHIFT);
        step    = (acc_q != '0) && (cnt_q >= period);
        dir_neg = acc_neg ^ flip;
    end

    // A packet and a step landing on the same cycle are both applied.
    always_comb begin
        acc_ext = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
        sum     = acc_ext;
        if (in_valid) begin
            sum = sum + scaled;
        end
        if (step) begin
            sum = acc_neg ? sum + SUM_ONE : sum - SUM_ONE;
        end
        if (sum > SAT_MAX) begin
            acc_d = SAT_MAX[ACC_W-1:0];
        end else if (sum < SAT_MIN) begin
            acc_d = SAT_MIN[ACC_W-1:0];
        end else begin
            acc_d = sum[ACC_W-1:0];
        end
    end

    // cnt keeps running across a mid-period sign reversal of the backlog.
    always_comb begin
        if (acc_q == '0) begin
            cnt_d = '0;
        end else if (step) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    if (MODE == MODE_QUAD) begin : g_quad
        logic [1:0] phase_q, phase_d;

        always_comb begin
            phase_d = phase_q;
            if (step) begin
                phase_d = dir_neg ? phase_q - 2'd1 : phase_q + 2'd1;
            end
            {qa_d, qb_d} = gray2(phase_d);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                phase_q <= 2'd0;
            end else begin
                phase_q <= phase_d;
            end
        end
    end else begin : g_clkdir
        always_comb begin
            qa_d = qa_q;
            qb_d = qb_q;
            if (step) begin
                qa_d = dir_neg;
                qb_d = ~qb_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            qa_q   <= 1'b0;
            qb_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            qa_q   <= qa_d;
            qb_q   <= qb_d;
            busy_q <= (acc_d != '0);
        end
    end

    assign q_a  = qa_q;
    assign q_b  = qb_q;
    assign busy = busy_q;

endmodule

// File: rtl/quad_emu.sv
// Multi-axis trackball/spinner emulator: slices the packed motion packet and
// runs one independent step channel per axis.
module quad_emu
    import quad_emu_pkg::*;
#(
    parameter int unsigned AXES       = 2,
    parameter int unsigned MODE       = MODE_CLKDIR,
    parameter int unsigned ACC_W      = 10,
    parameter int unsigned BASE_DIV   = 3500,
    parameter int unsigned RATE_SHIFT = 4
) (
    input  logic       clk,
    input  logic       reset,
    quad_emu_if.slave  bus
);

    for (genvar n = 0; n < AXES; n++) begin : g_axis
        quad_emu_axis #(
            .MODE       (MODE),
            .ACC_W      (ACC_W),
            .BASE_DIV   (BASE_DIV),
            .RATE_SHIFT (RATE_SHIFT)
        ) u_axis (
            .clk      (clk),
            .reset    (reset),
            .in_valid (bus.in_valid),
            .delta    (bus.in_delta[n*DELTA_W +: DELTA_W]),
            .speed    (bus.speed),
            .flip     (bus.flip[n]),
            .q_a      (bus.q_a[n]),
            .q_b      (bus.q_b[n]),
            .busy     (bus.busy[n])
        );
    end

endmodule

// File: tb/tb_quad_emu.sv
// Scoreboard bench for quad_emu: a quadrature and a clock/direction instance
// share stimulus; every output edge is matched against a queued expectation.
module tb_quad_emu;
    import quad_emu_pkg::*;

    localparam int ACC_MAX = 511;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [17:0] in_delta;
    logic [1:0]  speed;
    logic [1:0]  flip;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Channels 0/1: quadrature axes 0/1; channels 2/3: clock/direction axes 0/1.
    logic [1:0] exp_q [4][$];
    int         pend [4];
    int         step_cnt [4];
    int         last_step_cyc [4];
    logic [1:0] prev [4];
    logic [1:0] ph [4];
    logic       qb [4];
    int         last_send_cyc;

    quad_emu_if #(.AXES(2)) bus_q ();
    quad_emu_if #(.AXES(2)) bus_c ();

    assign bus_q.in_valid = in_valid;
    assign bus_q.in_delta = in_delta;
    assign bus_q.speed    = speed;
    assign bus_q.flip     = flip;
    assign bus_c.in_valid = in_valid;
    assign bus_c.in_delta = in_delta;
    assign bus_c.speed    = speed;
    assign bus_c.flip     = flip;

    quad_emu #(
        .AXES(2), .MODE(1), .ACC_W(10), .BASE_DIV(4), .RATE_SHIFT(0)
    ) dut_q (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_q)
    );

    quad_emu #(
        .AXES(2), .MODE(0), .ACC_W(10), .BASE_DIV(4), .RATE_SHIFT(0)
    ) dut_c (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] get_obs(input int c);
        case (c)
            0:       return {bus_q.q_a[0], bus_q.q_b[0]};
            1:       return {bus_q.q_a[1], bus_q.q_b[1]};
            2:       return {bus_c.q_a[0], bus_c.q_b[0]};
            default: return {bus_c.q_a[1], bus_c.q_b[1]};
        endcase
    endfunction

    function automatic logic [1:0] tb_gray(input logic [1:0] p);
        case (p)
            2'd0:    return 2'b00;
            2'd1:    return 2'b01;
            2'd2:    return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int model_scale(input int d, input logic [1:0] spd);
        int m;
        m = (d < 0) ? -d : d;
        case (spd)
            SPEED_X2:      m = m * 2;
            SPEED_HALF:    m = m / 2;
            SPEED_QUARTER: m = m / 4;
            default:       m = m;
        endcase
        return (d < 0) ? -m : m;
    endfunction

    function automatic int model_sat(input int x);
        if (x > ACC_MAX) return ACC_MAX;
        if (x < -ACC_MAX) return -ACC_MAX;
        return x;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic push_step(input int c, input logic neg);
        if (c < 2) begin
            ph[c] = neg ? ph[c] - 2'd1 : ph[c] + 2'd1;
            exp_q[c].push_back(tb_gray(ph[c]));
        end else begin
            qb[c] = ~qb[c];
            exp_q[c].push_back({neg, qb[c]});
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < 4; c++) begin
            exp_q[c].delete();
            pend[c]     = 0;
            ph[c]       = 2'd0;
            qb[c]       = 1'b0;
            step_cnt[c] = 0;
        end
    endtask

    task automatic zero_cnt();
        for (int c = 0; c < 4; c++) step_cnt[c] = 0;
    endtask

    // Call just after a rising edge; the packet is sampled on the next edge.
    task automatic send(input int d0, input int d1, input logic [1:0] spd);
        for (int c = 0; c < 4; c++) begin
            int   sc;
            int   nw;
            int   n;
            logic neg;
            sc  = model_scale((c % 2 == 0) ? d0 : d1, spd);
            nw  = model_sat(pend[c] + sc);
            n   = iabs(nw) - iabs(pend[c]);
            neg = (nw < 0) ^ flip[c % 2];
            for (int k = 0; k < n; k++) push_step(c, neg);
            pend[c] = nw;
        end
        speed    = spd;
        in_delta = {d1[8:0], d0[8:0]};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        last_send_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_steps(input int c, input int n, input int limit, input string tag);
        int g = 0;
        while (step_cnt[c] < n && g < limit) begin
            @(negedge clk);
            g++;
        end
        if (step_cnt[c] < n) check_val({tag, "_timeout"}, step_cnt[c], n);
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
               && g < 40000) begin
            @(posedge clk);
            g++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, "_left"},
                  exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
        check_val({tag, "_busy"}, int'({bus_c.busy, bus_q.busy}), 0);
        check_val({tag, "_pend"}, iabs(pend[0]) + iabs(pend[1]) + iabs(pend[2]) + iabs(pend[3]), 0);
    endtask

    task automatic expect_steps(input string tag, input int e0, input int e1);
        check_val({tag, "_n_q0"}, step_cnt[0], e0);
        check_val({tag, "_n_q1"}, step_cnt[1], e1);
        check_val({tag, "_n_c0"}, step_cnt[2], e0);
        check_val({tag, "_n_c1"}, step_cnt[3], e1);
    endtask

    // Edge monitor: every output change must be the next queued step.
    initial begin
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (reset) begin
                    prev[c] = 2'b00;
                end else if (get_obs(c) != prev[c]) begin
                    step_cnt[c]++;
                    last_step_cyc[c] = cyc;
                    if (exp_q[c].size() == 0) begin
                        check_val($sformatf("unexpected_edge_ch%0d", c), 1, 0);
                    end else begin
                        check_val($sformatf("step_ch%0d", c), int'(get_obs(c)),
                                  int'(exp_q[c].pop_front()));
                    end
                    if (pend[c] > 0) pend[c]--;
                    else if (pend[c] < 0) pend[c]++;
                    prev[c] = get_obs(c);
                end
            end
        end
    end

    initial begin
        int t [3];
        reset    = 1'b1;
        in_valid = 1'b0;
        in_delta = '0;
        speed    = SPEED_X1;
        flip     = 2'b00;
        clear_model();

        // Reset state and quiet outputs
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("rst_q", int'({bus_c.q_a, bus_c.q_b, bus_q.q_a, bus_q.q_b}), 0);
        check_val("rst_busy", int'({bus_c.busy, bus_q.busy}), 0);
        zero_cnt();
        repeat (2000) @(posedge clk);
        #1;
        check_val("idle_edges", step_cnt[0] + step_cnt[1] + step_cnt[2] + step_cnt[3], 0);

        // +3 at x1: Gray sequence and backlog-dependent spacing
        zero_cnt();
        send(3, 0, SPEED_X1);
        for (int k = 0; k < 3; k++) begin
            wait_steps(0, k + 1, 2000, "t2");
            t[k] = last_step_cyc[0];
            if (k == 1) check_val("t2_busy_mid", int'(bus_q.busy[0]), 1);
            if (k == 2) check_val("t2_busy_end", int'(bus_q.busy[0]), 0);
        end
        check_val("t2_lat", t[0] - last_send_cyc, 257);
        check_val("t2_gap1", t[1] - t[0], 258);
        check_val("t2_gap2", t[2] - t[1], 259);
        drain("t2");
        expect_steps("t2", 3, 0);

        // Flip: -2 runs forward with flip, backward without
        zero_cnt();
        flip = 2'b01;
        repeat (5) @(posedge clk);
        #1;
        send(-2, 0, SPEED_X1);
        drain("t3a");
        expect_steps("t3a", 2, 0);
        zero_cnt();
        flip = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        send(-2, 0, SPEED_X1);
        drain("t3b");
        expect_steps("t3b", 2, 0);

        // Speed codes, including truncation toward zero
        zero_cnt();
        send(5, 7, SPEED_QUARTER);
        drain("t4a");
        expect_steps("t4a", 1, 1);
        zero_cnt();
        send(-1, -3, SPEED_QUARTER);
        check_val("t4_trunc_busy", int'({bus_c.busy, bus_q.busy}), 0);
        send(-3, 20, SPEED_HALF);
        drain("t4b");
        expect_steps("t4b", 1, 10);

        // x2 on axis 0 alongside saturation on axis 1
        zero_cnt();
        send(200, 255, SPEED_X2);
        send(0, 255, SPEED_X2);
        send(0, 255, SPEED_X2);
        send(0, 255, SPEED_X2);
        check_val("t5_busy", int'({bus_c.busy, bus_q.busy}), 15);
        drain("t5");
        expect_steps("t5", 400, 511);

        // Packet landing exactly on the step cycle of acc = +1
        zero_cnt();
        send(1, 0, SPEED_X1);
        repeat (258) @(posedge clk);
        #1;
        send(1, 0, SPEED_X1);
        check_val("t6_busy_after", int'(bus_q.busy[0]), 1);
        drain("t6");
        expect_steps("t6", 2, 0);

        // Reset mid-operation discards the backlog
        zero_cnt();
        send(50, -50, SPEED_X1);
        wait_steps(0, 3, 2000, "t7");
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        check_val("t7_q", int'({bus_c.q_a, bus_c.q_b, bus_q.q_a, bus_q.q_b}), 0);
        check_val("t7_busy", int'({bus_c.busy, bus_q.busy}), 0);
        repeat (1000) @(posedge clk);
        #1;
        check_val("t7_edges", step_cnt[0] + step_cnt[1] + step_cnt[2] + step_cnt[3], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
